// File: rtl/synth_pkg.sv
// Shared constants for the FM envelope path: default channel geometry and the
// sequencer state encoding.
package synth_pkg;

  localparam int DEF_NUM_CHAN = 16;
  localparam int DEF_CHAN_W   = 4;
  localparam int DEF_CNT_W    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SWEEP = ST_SWEEP,
    DONE  = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/chan_onehot_decode.sv
// Binary channel index to one-hot select, gated by i_en; combinational, no backpressure.
// Indices >= NUM_CHAN decode to all-zero.
module chan_onehot_decode
  import synth_pkg::*;
#(
  parameter int CHAN_W   = DEF_CHAN_W,
  parameter int NUM_CHAN = DEF_NUM_CHAN
) (
  input  logic                i_en,
  input  logic [CHAN_W-1:0]   i_idx,
  output logic [NUM_CHAN-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      o_onehot[i] = i_en && (i_idx == CHAN_W'(i));
    end
  end

endmodule

// File: rtl/mod_chan_sequencer.sv
// Per-sample channel sweep (first strobe 1 cycle after tick, NUM_CHAN+1 busy cycles) plus note gates;
// events are held off (evt_ready low) while busy. OVERRUN_CNT_EN enables the dropped-tick counter.
module mod_chan_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int CHAN_W   = DEF_CHAN_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                evt_valid,
  output logic                evt_ready,
  input  logic                evt_on,
  input  logic [CHAN_W-1:0]   evt_chan,
  output logic [NUM_CHAN-1:0] curr_note,
  output logic [NUM_CHAN-1:0] acc_en,
  output logic [NUM_CHAN-1:0] note_enable,
  output logic [CHAN_W-1:0]   chan_idx,
  output logic                sweep_busy,
  output logic                sweep_done,
  output logic [CNT_W-1:0]    overrun_cnt
);

  localparam logic [CHAN_W-1:0] LAST_IDX = CHAN_W'(NUM_CHAN - 1);

  seq_state_t            r_state, w_state_nxt;
  logic [CHAN_W-1:0]     r_chan_idx, w_chan_idx_nxt;
  logic [NUM_CHAN-1:0]   r_note_enable;
  logic [NUM_CHAN-1:0]   w_chan_sel;
  logic                  w_sel_en;
  logic                  w_evt_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_chan_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_chan_idx <= w_chan_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_chan_idx_nxt = r_chan_idx;
    w_sel_en       = 1'b0;
    evt_ready      = 1'b0;
    sweep_busy     = 1'b0;
    sweep_done     = 1'b0;
    case (r_state)
      IDLE: begin
        evt_ready      = ~rst;
        w_chan_idx_nxt = '0;
        if (sample_tick) w_state_nxt = SWEEP;
      end
      SWEEP: begin
        w_sel_en   = 1'b1;
        sweep_busy = 1'b1;
        // Wrap at the last real channel so a non-power-of-two count never overshoots.
        if (r_chan_idx == LAST_IDX) begin
          w_state_nxt    = DONE;
          w_chan_idx_nxt = '0;
        end else begin
          w_chan_idx_nxt = r_chan_idx + CHAN_W'(1);
        end
      end
      DONE: begin
        sweep_busy  = 1'b1;
        sweep_done  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_evt_fire = evt_valid & evt_ready;

  // Out-of-range channels match no bit, so such events are accepted and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note_enable <= '0;
    end else if (w_evt_fire) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (evt_chan == CHAN_W'(i)) r_note_enable[i] <= evt_on;
      end
    end
  end

  chan_onehot_decode #(
    .CHAN_W   (CHAN_W),
    .NUM_CHAN (NUM_CHAN)
  ) u_dec (
    .i_en     (w_sel_en),
    .i_idx    (r_chan_idx),
    .o_onehot (w_chan_sel)
  );

  assign curr_note   = w_chan_sel;
  assign acc_en      = w_chan_sel;
  assign note_enable = r_note_enable;
  assign chan_idx    = r_chan_idx;

`ifdef OVERRUN_CNT_EN
  logic [CNT_W-1:0] r_overrun_cnt;
  logic             w_tick_drop;

  assign w_tick_drop = sample_tick & (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun_cnt <= '0;
    end else if (w_tick_drop && (r_overrun_cnt != {CNT_W{1'b1}})) begin
      r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`else
  assign overrun_cnt = '0;
`endif

endmodule
